dcache_sa_controller: RTL and testbench
=======================================

Name: dcache_sa_controller

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data cache controller for the MEM stage of the pipelined CPU.
- Next generation of the direct-mapped dcache controller. Adds configurable ways, sets and line size, per-set LRU replacement, and dirty-victim writeback.
- Sits between the MEM-stage load/store signals and the line-wide external memory handshake. Requests the pipeline stall through cpu_stall_o.

Parameters:
- WAYS, 2, associativity; power of 2, 1..8.
- SETS, 16, sets per way; power of 2, at least 2.
- LINE_BYTES, 32, bytes per line; power of 2, at least 4. Line width LW = 8*LINE_BYTES.
- ADDR_W, 32, address width.

Ports:
- Clk_i  in  1  clock.
- Rst_i  in  1  reset; asynchronous, active-low.
- cpu_MemRead_i  in  1  load request.
- cpu_MemWrite_i  in  1  store request; never asserted together with cpu_MemRead_i.
- cpu_addr_i  in  ADDR_W  byte address; bits [1:0] are ignored.
- cpu_data_i  in  32  store word.
- cpu_data_o  out  32  load word.
- cpu_stall_o  out  1  pipeline stall request.
- mem_data_i  in  LW  refill line.
- mem_ack_i  in  1  single-cycle completion pulse from memory.
- mem_data_o  out  LW  writeback line.
- mem_addr_o  out  ADDR_W  line-aligned address; offset bits are zero.
- mem_enable_o  out  1  memory request.
- mem_write_o  out  1  1 = writeback, 0 = refill.

Behaviour:
- Address split: offset = low log2(LINE_BYTES) bits; index = next log2(SETS) bits; tag = remaining bits. Word select = offset[.. :2].
- Per line storage: valid, dirty, tag, LW-bit data. Per set: one age value per way, log2(WAYS) bits wide.
- Reset (Rst_i low, asynchronous):
  - All valid and dirty bits cleared; ages initialised to way index.
  - FSM goes to IDLE.
  - cpu_data_o=0, cpu_stall_o=0, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0.
  - Dirty data is discarded. Reset mid-transaction abandons the transaction with no further mem_enable_o.
- Hit = request active, in IDLE, and some way has valid=1 with a matching tag.
  - Load hit: cpu_data_o is the selected word, combinationally in the same cycle; cpu_stall_o=0.
  - Store hit: at the clock edge, the word is written and dirty is set.
  - Either hit: the hit way's age becomes 0 and ages below its old age increment.
  - No request: cpu_data_o=0 and cpu_stall_o=0.
- cpu_stall_o = request active AND NOT (IDLE AND hit). Combinational.
- Victim selection on a miss: the lowest-index invalid way; otherwise the way with age WAYS-1. Selection is latched at the IDLE-to-miss transition.
- FSM:
  - IDLE: miss with a dirty victim -> WRITEBACK; miss with a clean or invalid victim -> ALLOCATE.
  - WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o = {victim tag, index, 0}, mem_data_o = victim line. On mem_ack_i -> ALLOCATE.
  - ALLOCATE: mem_enable_o=1, mem_write_o=0, mem_addr_o = {req tag, index, 0}. On mem_ack_i, capture mem_data_i -> INSTALL.
  - INSTALL: write the captured line into the victim way (valid=1, dirty=0, new tag). Victim age is not touched -> IDLE.
  - On re-entry to IDLE the held request hits; a store then sets dirty in that cycle.
- mem_enable_o is held high until mem_ack_i and drops in the cycle after the ack. mem_ack_i is ignored outside WRITEBACK and ALLOCATE.
- Clean-miss latency: miss seen in cycle T; ALLOCATE from T+1; ack in cycle A; INSTALL in A+1; hit and stall low in A+2.
  - A dirty miss adds the writeback handshake.
- The CPU holds the request stable while stalled. If the request drops mid-miss, the FSM still completes through INSTALL.
- Ack in the first ALLOCATE or WRITEBACK cycle is legal (zero wait).

Decomposition:
- Shared constants header (Const.v): FSM state encodings (IDLE, WRITEBACK, ALLOCATE, INSTALL) and the mem_write_o read/write encodings.
- One natural sub-module: dcache_lru_sets. Holds the per-set age arrays, performs the hit update, and outputs the victim way for an index.
- Tag, valid, dirty and data arrays stay in the top module.

Test Plan (WAYS=2, SETS=16, LINE_BYTES=32):
1. Reset, then load 0x400.
   - Required: stall_o=1 the same cycle; next cycle mem_enable_o=1, mem_write_o=0, mem_addr_o=0x400.
   - Memory acks after 3 cycles with word0=0xDEADBEEF: two cycles after the ack, stall_o=0 and cpu_data_o=0xDEADBEEF.
2. Store 0x12345678 to 0x404 (a hit).
   - Required: no stall, mem_enable_o stays 0; a following load of 0x404 returns 0x12345678.
3. Fill both ways at 0x400 and 0x600, touch 0x400, then load 0x800.
   - Required: no writeback; ALLOCATE at 0x800 replaces the 0x600 line.
   - A subsequent load of 0x400 hits.
4. Store 0xCAFEF00D to 0x600, touch 0x400, then load 0x800.
   - Required: WRITEBACK with mem_addr_o=0x600, mem_write_o=1, and word0 of mem_data_o = 0xCAFEF00D.
   - Then ALLOCATE at 0x800; stall is held throughout both handshakes.
5. Load miss with mem_ack_i delayed 10 cycles.
   - Required: mem_enable_o and stall_o stay high for all 10 cycles; a spurious ack pulsed while in IDLE is ignored.
6. Pull Rst_i low during ALLOCATE.
   - Required: mem_enable_o=0 and stall_o=0 immediately.
   - After release, a load of 0x400 misses again, because valid was cleared.

Source files
------------

// File: rtl/dcache_sa_controller_pkg.sv
// ---------------------------------------------------------------------------
// dcache_sa_controller_pkg
// Shared definitions for the set-associative data cache controller:
//   - cache_state_t : controller FSM states
//   - MEM_OP_READ / MEM_OP_WRITE : encodings driven on mem_write_o
//   - clog2_min1 : log2 helper that never returns a zero width
// ---------------------------------------------------------------------------
package dcache_sa_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2,
        ST_INSTALL   = 2'd3
    } cache_state_t;

    localparam logic MEM_OP_READ  = 1'b0;
    localparam logic MEM_OP_WRITE = 1'b1;

    // A direct-mapped build (one way) still needs a 1-bit way/age field.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/dcache_lru_sets.sv
// ---------------------------------------------------------------------------
// dcache_lru_sets
// Per-set age-based LRU state for the set-associative data cache.
// Each way of each set carries an age; 0 is most recently used and WAYS-1
// is least recently used. The ages of a set always form a permutation.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (ages = way index)
//   hit_en      : a hit occurred this cycle; update the set at the edge
//   hit_idx     : set index of the hit
//   hit_way     : way that hit
//   query_idx   : set index whose replacement candidate is requested
//   victim_way  : way holding age WAYS-1 in set query_idx
// ---------------------------------------------------------------------------
module dcache_lru_sets
    import dcache_sa_controller_pkg::*;
#(
    parameter int WAYS = 2,
    parameter int SETS = 16,
    localparam int WAY_W = clog2_min1(WAYS),
    localparam int IDX_W = clog2_min1(SETS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hit_en,
    input  logic [IDX_W-1:0] hit_idx,
    input  logic [WAY_W-1:0] hit_way,
    input  logic [IDX_W-1:0] query_idx,
    output logic [WAY_W-1:0] victim_way
);

    logic [WAY_W-1:0] age [SETS][WAYS];
    logic [WAY_W-1:0] hit_old_age;

    assign hit_old_age = age[hit_idx][hit_way];

    // On a hit the hit way becomes youngest and every way that was younger
    // than it ages by one; older ways keep their age, so the set stays a
    // permutation of 0..WAYS-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age[s][w] <= WAY_W'(w);
                end
            end
        end else if (hit_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == hit_way) begin
                    age[hit_idx][w] <= '0;
                end else if (age[hit_idx][w] < hit_old_age) begin
                    age[hit_idx][w] <= age[hit_idx][w] + WAY_W'(1);
                end
            end
        end
    end

    always_comb begin
        victim_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (age[query_idx][w] == WAY_W'(WAYS - 1)) begin
                victim_way = WAY_W'(w);
            end
        end
    end

endmodule

// File: rtl/dcache_sa_controller.sv
// ---------------------------------------------------------------------------
// dcache_sa_controller
// N-way set-associative, write-back, write-allocate data cache controller
// for the MEM stage. Hits are served combinationally; misses stall the
// pipeline while an optional dirty-victim writeback and a line refill run
// over the line-wide memory handshake.
// Ports:
//   Clk_i, Rst_i           : clock, asynchronous active-low reset
//   cpu_MemRead_i/Write_i  : load / store request (mutually exclusive)
//   cpu_addr_i             : byte address (bits [1:0] ignored)
//   cpu_data_i / _o        : store word in / load word out
//   cpu_stall_o            : stall request to the pipeline
//   mem_data_i, mem_ack_i  : refill line and one-cycle completion pulse
//   mem_data_o, mem_addr_o : writeback line and line-aligned address
//   mem_enable_o           : memory request
//   mem_write_o            : 1 = writeback, 0 = refill
// ---------------------------------------------------------------------------
module dcache_sa_controller
    import dcache_sa_controller_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 16,
    parameter int LINE_BYTES = 32,
    parameter int ADDR_W     = 32,
    localparam int LW        = 8 * LINE_BYTES
) (
    input  logic              Clk_i,
    input  logic              Rst_i,
    input  logic              cpu_MemRead_i,
    input  logic              cpu_MemWrite_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    input  logic [LW-1:0]     mem_data_i,
    input  logic              mem_ack_i,
    output logic [LW-1:0]     mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o
);

    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
    localparam int WAY_W = clog2_min1(WAYS);
    localparam int WORDS = LINE_BYTES / 4;

    cache_state_t state_q, state_d;

    logic             valid_q [WAYS][SETS];
    logic             dirty_q [WAYS][SETS];
    logic [TAG_W-1:0] tag_q   [WAYS][SETS];
    logic [LW-1:0]    data_q  [WAYS][SETS];

    // Miss context, frozen when the FSM leaves IDLE so the transaction can
    // finish even if the CPU withdraws its request.
    logic [WAY_W-1:0] victim_q;
    logic [IDX_W-1:0] miss_idx_q;
    logic [TAG_W-1:0] miss_tag_q;
    logic [LW-1:0]    refill_q;

    logic             req;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [ADDR_W-1:0] word_sel;
    logic             hit_any;
    logic [WAY_W-1:0] hit_way;
    logic [LW-1:0]    hit_line;
    logic [31:0]      hit_word;
    logic             idle_hit;
    logic [WAY_W-1:0] lru_victim;
    logic [WAY_W-1:0] miss_victim;
    logic             invalid_found;

    assign req      = cpu_MemRead_i | cpu_MemWrite_i;
    assign req_idx  = cpu_addr_i[OFF_W +: IDX_W];
    assign req_tag  = cpu_addr_i[OFF_W + IDX_W +: TAG_W];
    assign word_sel = (cpu_addr_i >> 2) & ADDR_W'(WORDS - 1);

    always_comb begin
        hit_any  = 1'b0;
        hit_way  = '0;
        hit_line = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit_any && valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
                hit_any  = 1'b1;
                hit_way  = WAY_W'(w);
                hit_line = data_q[w][req_idx];
            end
        end
    end

    always_comb begin
        hit_word = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (word_sel == ADDR_W'(w)) begin
                hit_word = hit_line[w*32 +: 32];
            end
        end
    end

    assign idle_hit = req && (state_q == ST_IDLE) && hit_any;

    // CPU-side outputs are gated by reset so the pipeline is released the
    // moment reset is asserted, even with a request still presented.
    assign cpu_data_o  = (Rst_i && cpu_MemRead_i && idle_hit) ? hit_word : 32'd0;
    assign cpu_stall_o = Rst_i && req && !idle_hit;

    dcache_lru_sets #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_lru (
        .clk        (Clk_i),
        .rst_n      (Rst_i),
        .hit_en     (idle_hit),
        .hit_idx    (req_idx),
        .hit_way    (hit_way),
        .query_idx  (req_idx),
        .victim_way (lru_victim)
    );

    // Empty ways are filled lowest index first before LRU eviction starts.
    always_comb begin
        invalid_found = 1'b0;
        miss_victim   = lru_victim;
        for (int w = 0; w < WAYS; w++) begin
            if (!invalid_found && !valid_q[w][req_idx]) begin
                invalid_found = 1'b1;
                miss_victim   = WAY_W'(w);
            end
        end
    end

    always_ff @(posedge Clk_i or negedge Rst_i) begin
        if (!Rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_enable_o = 1'b0;
        mem_write_o  = MEM_OP_READ;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        case (state_q)
            ST_IDLE: begin
                if (req && !hit_any) begin
                    if (valid_q[miss_victim][req_idx] && dirty_q[miss_victim][req_idx]) begin
                        state_d = ST_WRITEBACK;
                    end else begin
                        state_d = ST_ALLOCATE;
                    end
                end
            end
            ST_WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = MEM_OP_WRITE;
                mem_addr_o   = {tag_q[victim_q][miss_idx_q], miss_idx_q, {OFF_W{1'b0}}};
                mem_data_o   = data_q[victim_q][miss_idx_q];
                if (mem_ack_i) begin
                    state_d = ST_ALLOCATE;
                end
            end
            ST_ALLOCATE: begin
                mem_enable_o = 1'b1;
                mem_write_o  = MEM_OP_READ;
                mem_addr_o   = {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
                if (mem_ack_i) begin
                    state_d = ST_INSTALL;
                end
            end
            ST_INSTALL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Capture the miss context on leaving IDLE and the refill line on ack.
    always_ff @(posedge Clk_i or negedge Rst_i) begin
        if (!Rst_i) begin
            victim_q   <= '0;
            miss_idx_q <= '0;
            miss_tag_q <= '0;
            refill_q   <= '0;
        end else begin
            if ((state_q == ST_IDLE) && (state_d != ST_IDLE)) begin
                victim_q   <= miss_victim;
                miss_idx_q <= req_idx;
                miss_tag_q <= req_tag;
            end
            if ((state_q == ST_ALLOCATE) && mem_ack_i) begin
                refill_q <= mem_data_i;
            end
        end
    end

    // Valid/dirty are the only line state that must be cleared on reset;
    // dirty contents are simply dropped.
    always_ff @(posedge Clk_i or negedge Rst_i) begin
        if (!Rst_i) begin
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                end
            end
        end else if (state_q == ST_INSTALL) begin
            valid_q[victim_q][miss_idx_q] <= 1'b1;
            dirty_q[victim_q][miss_idx_q] <= 1'b0;
        end else if (idle_hit && cpu_MemWrite_i) begin
            dirty_q[hit_way][req_idx] <= 1'b1;
        end
    end

    // Tag and data storage need no reset; valid qualifies every use.
    always_ff @(posedge Clk_i) begin
        if (state_q == ST_INSTALL) begin
            tag_q[victim_q][miss_idx_q]  <= miss_tag_q;
            data_q[victim_q][miss_idx_q] <= refill_q;
        end else if (idle_hit && cpu_MemWrite_i) begin
            for (int w = 0; w < WORDS; w++) begin
                if (word_sel == ADDR_W'(w)) begin
                    data_q[hit_way][req_idx][w*32 +: 32] <= cpu_data_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_dcache_sa_controller.sv
// ---------------------------------------------------------------------------
// tb_dcache_sa_controller
// Self-checking bench for dcache_sa_controller (WAYS=2, SETS=16,
// LINE_BYTES=32). The bench models each set as a recency-ordered list of
// resident lines and plays the memory side itself.
// ---------------------------------------------------------------------------
module tb_dcache_sa_controller;

    localparam int WAYS       = 2;
    localparam int SETS       = 16;
    localparam int LINE_BYTES = 32;
    localparam int ADDR_W     = 32;
    localparam int LW         = 8 * LINE_BYTES;

    typedef struct {
        logic [22:0]   tag;
        logic [LW-1:0] data;
        bit            dirty;
    } entry_t;

    logic              Clk_i;
    logic              Rst_i;
    logic              cpu_MemRead_i;
    logic              cpu_MemWrite_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic [31:0]       cpu_data_i;
    logic [31:0]       cpu_data_o;
    logic              cpu_stall_o;
    logic [LW-1:0]     mem_data_i;
    logic              mem_ack_i;
    logic [LW-1:0]     mem_data_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_enable_o;
    logic              mem_write_o;

    // Each set: most recently used line at the front, eviction from the back.
    entry_t        model_set [SETS][$];
    logic [LW-1:0] mem_model [logic [31:0]];

    int errors = 0;
    int checks = 0;

    dcache_sa_controller #(
        .WAYS       (WAYS),
        .SETS       (SETS),
        .LINE_BYTES (LINE_BYTES),
        .ADDR_W     (ADDR_W)
    ) dut (
        .Clk_i          (Clk_i),
        .Rst_i          (Rst_i),
        .cpu_MemRead_i  (cpu_MemRead_i),
        .cpu_MemWrite_i (cpu_MemWrite_i),
        .cpu_addr_i     (cpu_addr_i),
        .cpu_data_i     (cpu_data_i),
        .cpu_data_o     (cpu_data_o),
        .cpu_stall_o    (cpu_stall_o),
        .mem_data_i     (mem_data_i),
        .mem_ack_i      (mem_ack_i),
        .mem_data_o     (mem_data_o),
        .mem_addr_o     (mem_addr_o),
        .mem_enable_o   (mem_enable_o),
        .mem_write_o    (mem_write_o)
    );

    initial Clk_i = 1'b0;
    always #5 Clk_i = ~Clk_i;

    task automatic checkOutput(input string tag, input logic [LW-1:0] observed,
                               input logic [LW-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Backing memory contents; untouched lines hold an address-derived pattern.
    function automatic logic [LW-1:0] get_line(input logic [31:0] laddr);
        logic [LW-1:0] line;
        if (mem_model.exists(laddr)) return mem_model[laddr];
        for (int k = 0; k < LINE_BYTES / 4; k++) begin
            line[k*32 +: 32] = laddr ^ (32'h01010101 * (k + 1)) ^ 32'hA5000000;
        end
        return line;
    endfunction

    task automatic next_cycle();
        @(posedge Clk_i);
        #1;
        mem_ack_i = 1'b0;
    endtask

    task automatic reset_model();
        for (int s = 0; s < SETS; s++) model_set[s].delete();
    endtask

    task automatic drop_request();
        next_cycle();
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
        #1;
        checkOutput("idle_stall", cpu_stall_o, 0);
        checkOutput("idle_data", cpu_data_o, 0);
        checkOutput("idle_enable", mem_enable_o, 0);
    endtask

    // One memory handshake; memory answers 'delay' cycles after the first
    // request cycle (0 = ack in the first cycle).
    task automatic handshake(input bit wb, input logic [31:0] laddr,
                             input logic [LW-1:0] line, input int delay);
        string ph;
        ph = wb ? "wb" : "alloc";
        for (int c = 0; c <= delay; c++) begin
            next_cycle();
            if (!wb) mem_data_i = line;
            mem_ack_i = (c == delay);
            #1;
            checkOutput({ph, "_enable"}, mem_enable_o, 1);
            checkOutput({ph, "_write"}, mem_write_o, wb);
            checkOutput({ph, "_addr"}, mem_addr_o, laddr);
            checkOutput({ph, "_stall"}, cpu_stall_o, 1);
            if (wb) checkOutput("wb_data", mem_data_o, line);
        end
    endtask

    // One CPU access, held until it completes, checked against the model.
    task automatic applyStimulus(input bit wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int delay);
        int            s;
        int            word;
        int            pos;
        logic [22:0]   tag;
        logic [31:0]   laddr;
        logic [31:0]   vaddr;
        entry_t        e;
        entry_t        victim;
        s     = int'(addr[8:5]);
        word  = int'(addr[4:2]);
        tag   = addr[31:9];
        laddr = {addr[31:5], 5'b0};
        pos   = -1;
        for (int i = 0; i < model_set[s].size(); i++) begin
            if (model_set[s][i].tag == tag) pos = i;
        end
        next_cycle();
        cpu_MemRead_i  = !wr;
        cpu_MemWrite_i = wr;
        cpu_addr_i     = addr;
        cpu_data_i     = wdata;
        #1;
        if (pos >= 0) begin
            checkOutput("hit_stall", cpu_stall_o, 0);
            checkOutput("hit_enable", mem_enable_o, 0);
            e = model_set[s][pos];
            model_set[s].delete(pos);
        end else begin
            checkOutput("miss_stall", cpu_stall_o, 1);
            checkOutput("miss_idle_enable", mem_enable_o, 0);
            if (model_set[s].size() == WAYS) begin
                victim = model_set[s].pop_back();
                if (victim.dirty) begin
                    vaddr = {victim.tag, addr[8:5], 5'b0};
                    handshake(1'b1, vaddr, victim.data, delay);
                    mem_model[vaddr] = victim.data;
                end
            end
            e.tag   = tag;
            e.data  = get_line(laddr);
            e.dirty = 1'b0;
            handshake(1'b0, laddr, e.data, delay);
            next_cycle();
            #1;
            checkOutput("install_stall", cpu_stall_o, 1);
            checkOutput("install_enable", mem_enable_o, 0);
            next_cycle();
            #1;
            checkOutput("refill_hit_stall", cpu_stall_o, 0);
            checkOutput("refill_hit_enable", mem_enable_o, 0);
        end
        if (!wr) begin
            checkOutput("load_data", cpu_data_o, e.data[word*32 +: 32]);
        end else begin
            e.data[word*32 +: 32] = wdata;
            e.dirty = 1'b1;
        end
        model_set[s].push_front(e);
    endtask

    initial begin
        logic [LW-1:0] seed_line;
        logic [31:0]   raddr;

        Rst_i          = 1'b1;
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
        cpu_addr_i     = '0;
        cpu_data_i     = '0;
        mem_data_i     = '0;
        mem_ack_i      = 1'b0;
        reset_model();
        seed_line = get_line(32'h400);
        seed_line[31:0] = 32'hDEADBEEF;
        mem_model[32'h400] = seed_line;

        #2 Rst_i = 1'b0;
        repeat (2) next_cycle();
        checkOutput("reset_data", cpu_data_o, 0);
        checkOutput("reset_stall", cpu_stall_o, 0);
        checkOutput("reset_enable", mem_enable_o, 0);
        checkOutput("reset_write", mem_write_o, 0);
        checkOutput("reset_addr", mem_addr_o, 0);
        checkOutput("reset_wdata", mem_data_o, 0);
        Rst_i = 1'b1;

        // Cold load miss, ack three cycles into the refill.
        applyStimulus(1'b0, 32'h400, 32'h0, 3);
        checkOutput("t1_deadbeef", cpu_data_o, 32'hDEADBEEF);

        // Store hit, then read back.
        applyStimulus(1'b1, 32'h404, 32'h12345678, 0);
        applyStimulus(1'b0, 32'h404, 32'h0, 0);
        checkOutput("t2_readback", cpu_data_o, 32'h12345678);

        // Fill both ways, touch 0x400, then 0x800 replaces the clean 0x600.
        applyStimulus(1'b0, 32'h600, 32'h0, 1);
        applyStimulus(1'b0, 32'h400, 32'h0, 0);
        applyStimulus(1'b0, 32'h800, 32'h0, 2);
        applyStimulus(1'b0, 32'h400, 32'h0, 0);

        // Dirty 0x600, touch 0x400, then 0x800 forces a writeback of 0x600.
        applyStimulus(1'b1, 32'h600, 32'hCAFEF00D, 0);
        applyStimulus(1'b0, 32'h400, 32'h0, 0);
        applyStimulus(1'b0, 32'h800, 32'h0, 1);
        checkOutput("t4_wb_word0", mem_model[32'h600][31:0], 32'hCAFEF00D);

        // Spurious ack while idle must not start anything.
        drop_request();
        next_cycle();
        mem_ack_i = 1'b1;
        #1;
        checkOutput("spurious_enable", mem_enable_o, 0);
        next_cycle();
        #1;
        checkOutput("spurious_enable_after", mem_enable_o, 0);
        checkOutput("spurious_stall_after", cpu_stall_o, 0);
        applyStimulus(1'b0, 32'h800, 32'h0, 0);

        // Long refill wait.
        applyStimulus(1'b0, 32'h1020, 32'h0, 10);

        // Reset in the middle of ALLOCATE.
        drop_request();
        next_cycle();
        cpu_MemRead_i = 1'b1;
        cpu_addr_i    = 32'h3040;
        #1;
        checkOutput("t6_miss_stall", cpu_stall_o, 1);
        next_cycle();
        #1;
        checkOutput("t6_alloc_enable", mem_enable_o, 1);
        checkOutput("t6_alloc_addr", mem_addr_o, 32'h3040);
        Rst_i = 1'b0;
        #1;
        checkOutput("t6_rst_enable", mem_enable_o, 0);
        checkOutput("t6_rst_stall", cpu_stall_o, 0);
        checkOutput("t6_rst_addr", mem_addr_o, 0);
        checkOutput("t6_rst_data", cpu_data_o, 0);
        reset_model();
        next_cycle();
        #1;
        checkOutput("t6_rst_hold_enable", mem_enable_o, 0);
        cpu_MemRead_i = 1'b0;
        next_cycle();
        Rst_i = 1'b1;
        applyStimulus(1'b0, 32'h400, 32'h0, 0);

        // Random traffic over a few sets and tags to exercise LRU and writebacks.
        for (int n = 0; n < 80; n++) begin
            raddr = {23'($urandom_range(1, 6)), 4'($urandom_range(0, 3)),
                     3'($urandom_range(0, 7)), 2'b00};
            applyStimulus(1'($urandom_range(0, 1)), raddr, $urandom, $urandom_range(0, 3));
        end
        drop_request();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
